// File: rtl/mux_tree_pipe_pkg.sv
// Shared sizing helpers for the pipelined N:1 selector: select width, latency,
// per-stage word counts and leaf padding.
package mux_tree_pipe_pkg;

    function automatic int unsigned f_clog2(input int unsigned n);
        int unsigned r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    function automatic int unsigned f_sw(input int unsigned n);
        return (f_clog2(n) > 0) ? f_clog2(n) : 1;
    endfunction

    function automatic int unsigned f_lat(input int unsigned n, input int unsigned lvls);
        int unsigned l = (f_clog2(n) + lvls - 1) / lvls;
        return (l > 0) ? l : 1;
    endfunction

    // Words remaining after s stages, each stage grouping 2^lvls words into one.
    function automatic int unsigned f_words(input int unsigned n, input int unsigned lvls,
                                            input int unsigned s);
        int unsigned w = n;
        for (int unsigned i = 0; i < s; i++) w = (w + (32'd1 << lvls) - 1) >> lvls;
        return w;
    endfunction

    // Leaf count of one stage once its input is padded to whole groups.
    function automatic int unsigned f_pad(input int unsigned n, input int unsigned lvls);
        return f_words(n, lvls, 1) << lvls;
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered stage of the selector tree: 2^LVLS:1 reduction of NI words,
// carrying valid, the unused select bits and the en_n/err flags alongside.
module mux_tree_stage
    import mux_tree_pipe_pkg::*;
#(
    parameter int unsigned NI   = 16,
    parameter int unsigned WE   = 1,
    parameter int unsigned LVLS = 2,
    parameter int unsigned SWI  = 5,
    parameter logic [WE-1:0] DIS = '1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 adv,
    input  logic                                 prev_valid,
    input  logic [NI*WE-1:0]                     prev_data,
    input  logic [SWI-1:0]                       prev_sel,
    input  logic                                 prev_en_n,
    input  logic                                 prev_err,
    output logic                                 valid,
    output logic [f_words(NI, LVLS, 1)*WE-1:0]   data,
    output logic [SWI-LVLS-1:0]                  sel,
    output logic                                 en_n,
    output logic                                 err
);

    localparam int unsigned GS = 2 ** LVLS;
    localparam int unsigned NO = f_words(NI, LVLS, 1);
    localparam int unsigned NP = f_pad(NI, LVLS);

    logic [NP*WE-1:0] padded;
    logic [NO*WE-1:0] red;
    logic [LVLS-1:0]  idx;

    always_comb begin
        padded = {NP{DIS}};
        padded[NI*WE-1:0] = prev_data;
        idx = prev_sel[LVLS-1:0];
        red = '0;
        for (int unsigned j = 0; j < NO; j++) begin
            // Disabled or out-of-range items collapse to DIS at every level.
            if (prev_en_n || prev_err) begin
                red[j*WE +: WE] = DIS;
            end else begin
                red[j*WE +: WE] = padded[(j*GS + 32'(idx))*WE +: WE];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            sel   <= '0;
            en_n  <= 1'b0;
            err   <= 1'b0;
        end else if (adv) begin
            valid <= prev_valid;
            data  <= red;
            sel   <= prev_sel[SWI-1:LVLS];
            en_n  <= prev_en_n;
            err   <= prev_err;
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 selector with valid/ready handshake and out-of-range detection.
// Define MUX_PARITY_EN to add the registered even-parity output out_par.
module mux_tree_pipe
    import mux_tree_pipe_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned W    = 1,
    parameter int unsigned LVLS = 2,
    parameter logic [W-1:0] DIS_VAL = '1,
    localparam int unsigned SW  = f_sw(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic [SW-1:0]   in_sel,
    input  logic            in_en_n,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef MUX_PARITY_EN
    output logic            out_par,
`endif
    output logic [W-1:0]    out_data,
    output logic            out_err
);

    localparam int unsigned LAT = f_lat(N, LVLS);
    // One spare select bit keeps every carried select field at least one bit wide.
    localparam int unsigned TSW = LAT * LVLS + 1;

`ifdef MUX_PARITY_EN
    // Parity rides as an extra top bit of each word, so it shares the output register.
    localparam int unsigned WE = W + 1;
    localparam logic [WE-1:0] DIS_EXT = {^DIS_VAL, DIS_VAL};
`else
    localparam int unsigned WE = W;
    localparam logic [WE-1:0] DIS_EXT = DIS_VAL;
`endif

    logic            adv;
    logic            in_err;
    logic [TSW-1:0]  sel_ext;
    logic [N*WE-1:0] data_ext;
    logic            unused_tail;

    always_comb begin
        data_ext = '0;
        for (int unsigned i = 0; i < N; i++) begin
`ifdef MUX_PARITY_EN
            data_ext[i*WE +: WE] = {^in_data[i*W +: W], in_data[i*W +: W]};
`else
            data_ext[i*WE +: WE] = in_data[i*W +: W];
`endif
        end
    end

    assign in_err   = !in_en_n && (32'(in_sel) >= N);
    assign sel_ext  = TSW'(in_sel);
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    for (genvar s = 0; s < LAT; s++) begin : g_stg
        localparam int unsigned NI  = f_words(N, LVLS, s);
        localparam int unsigned NO  = f_words(N, LVLS, s + 1);
        localparam int unsigned SWI = TSW - s * LVLS;

        logic                 p_valid;
        logic [NI*WE-1:0]     p_data;
        logic [SWI-1:0]       p_sel;
        logic                 p_en_n;
        logic                 p_err;
        logic                 valid;
        logic [NO*WE-1:0]     data;
        logic [SWI-LVLS-1:0]  sel;
        logic                 en_n;
        logic                 err;

        if (s == 0) begin : g_head
            assign p_valid = in_valid;
            assign p_data  = data_ext;
            assign p_sel   = sel_ext;
            assign p_en_n  = in_en_n;
            assign p_err   = in_err;
        end else begin : g_link
            assign p_valid = g_stg[s-1].valid;
            assign p_data  = g_stg[s-1].data;
            assign p_sel   = g_stg[s-1].sel;
            assign p_en_n  = g_stg[s-1].en_n;
            assign p_err   = g_stg[s-1].err;
        end

        mux_tree_stage #(
            .NI   (NI),
            .WE   (WE),
            .LVLS (LVLS),
            .SWI  (SWI),
            .DIS  (DIS_EXT)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .adv        (adv),
            .prev_valid (p_valid),
            .prev_data  (p_data),
            .prev_sel   (p_sel),
            .prev_en_n  (p_en_n),
            .prev_err   (p_err),
            .valid      (valid),
            .data       (data),
            .sel        (sel),
            .en_n       (en_n),
            .err        (err)
        );
    end

    assign out_valid = g_stg[LAT-1].valid;
    assign out_data  = g_stg[LAT-1].data[W-1:0];
    assign out_err   = g_stg[LAT-1].err;
`ifdef MUX_PARITY_EN
    assign out_par   = g_stg[LAT-1].data[W];
`endif

    // Select remainder and en_n of the last stage have no consumer.
    assign unused_tail = ^{g_stg[LAT-1].sel, g_stg[LAT-1].en_n};

endmodule
